// File: rtl/vx_writeback_arbiter.sv
// rtl/vx_writeback_arbiter.sv - round-robin writeback arbiter with packet lock and registered output
module vx_writeback_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATAW      = 256,
    parameter int PERF_W     = 32,
    localparam int SRC_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_sop,
    input  logic [NUM_INPUTS-1:0]       in_eop,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic                        out_valid,
    output logic [DATAW-1:0]            out_data,
    output logic                        out_sop,
    output logic                        out_eop,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready,
    output logic [PERF_W-1:0]           perf_stalls
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam logic [SRC_W:0] N_L = (SRC_W+1)'(NUM_INPUTS);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   lock_idx_q, lock_idx_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               out_valid_q;
    logic [DATAW-1:0]   out_data_q;
    logic               out_sop_q;
    logic               out_eop_q;
    logic [SRC_W-1:0]   out_src_q;
    logic [PERF_W-1:0]  perf_q;

    logic               load;
    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W:0]     scan_idx;
    logic               xfer;

    logic [DATAW-1:0]   in_data_arr [NUM_INPUTS];

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
        assign in_data_arr[i] = in_data[i*DATAW +: DATAW];
    end

    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] a);
        logic [SRC_W:0] s;
        s = {1'b0, a} + (SRC_W+1)'(1);
        if (s >= N_L) begin
            s = '0;
        end
        return s[SRC_W-1:0];
    endfunction

    // Pick the granted source: the locked owner, or the first valid source from rr_ptr onward.
    always_comb begin
        load        = !out_valid_q || out_ready;
        grant_found = 1'b0;
        grant_idx   = lock_idx_q;
        scan_idx    = '0;
        if (state_q == ST_LOCKED) begin
            grant_found = 1'b1;
        end else begin
            // Walk the offsets from farthest to nearest so the nearest valid source wins.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
                if (scan_idx >= N_L) begin
                    scan_idx = scan_idx - N_L;
                end
                if (in_valid[scan_idx[SRC_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = scan_idx[SRC_W-1:0];
                end
            end
        end
        in_ready = '0;
        if (grant_found && load && !reset) begin
            in_ready[grant_idx] = 1'b1;
        end
        xfer = grant_found && load && !reset && in_valid[grant_idx];
    end

    // Lock on a multi-beat start, release and advance the pointer on end of packet.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_sop[grant_idx] && !in_eop[grant_idx]) begin
                        state_d    = ST_LOCKED;
                        lock_idx_d = grant_idx;
                    end else begin
                        rr_ptr_d = wrap_inc(grant_idx);
                    end
                end
                ST_LOCKED: begin
                    if (in_eop[grant_idx]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = wrap_inc(lock_idx_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Output beat register: capture on transfer, drain when the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_src_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data_arr[grant_idx];
            out_sop_q   <= in_sop[grant_idx];
            out_eop_q   <= in_eop[grant_idx];
            out_src_q   <= grant_idx;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Count cycles where a beat is held back by the register file.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else if (out_valid_q && !out_ready) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign out_src     = out_src_q;
    assign perf_stalls = perf_q;

    a_idle_needs_sop: assert property (@(posedge clk) disable iff (reset)
        !(xfer && state_q == ST_IDLE && !in_sop[grant_idx]));

    a_locked_no_sop: assert property (@(posedge clk) disable iff (reset)
        !(xfer && state_q == ST_LOCKED && in_sop[grant_idx]));

endmodule
